fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL have parameter XLEN, default 32, width of instruction and PC fields.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  discard all queued entries (branch/return redirect).
REQ-006 SHALL have port in_valid  input  1  fetch side presents an entry this cycle.
REQ-007 SHALL have port in_inst  input  XLEN  fetched instruction.
REQ-008 SHALL have port in_pc  input  XLEN  PC of fetched instruction.
REQ-009 SHALL have port pc_stall  output  1  high when queue full; fetch PC holds.
REQ-010 SHALL have port out_valid  output  1  head entry available to decode.
REQ-011 SHALL have port out_inst  output  XLEN  head instruction.
REQ-012 SHALL have port out_pc  output  XLEN  head PC.
REQ-013 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL implement a circular buffer of DEPTH entries {inst, pc} with read pointer, write pointer, and occupancy counter.
REQ-016 SHALL accept push when in_valid=1, count<DEPTH, and flush=0; entry is written at the write pointer, which increments.
REQ-017 SHALL pop when out_valid=1 and out_ready=1; read pointer increments.
REQ-018 SHALL wrap pointers from DEPTH-1 to 0 without a gap.
REQ-019 SHALL keep count unchanged on a simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-020 SHALL drive pc_stall = (count==DEPTH), decoded from registered count only.
REQ-021 SHALL ignore in_valid while full, including cycles with a same-cycle pop; no overwrite and no count change from the push.
REQ-022 SHALL drive out_valid = (count!=0), with out_inst/out_pc taken from the head entry; 0 when empty.
REQ-023 SHALL make a pushed entry visible at out_valid no earlier than the next cycle (1-cycle latency) when the bypass is absent.
REQ-024 SHALL clear pointers and count on the edge where flush=1, dropping any same-cycle push and pop; out_valid=0 the next cycle.
REQ-025 SHALL ignore out_ready while out_valid=0; count never underflows.
REQ-026 SHALL preserve entry order exactly; FIFO semantics.

Reset
REQ-027 SHALL, on a clk edge with rst=1, set read pointer, write pointer, and count to 0; out_valid=0, pc_stall=0, out_inst=0, out_pc=0.
REQ-028 SHALL give rst priority over flush, push, and pop; an asserted rst mid-operation discards all entries.
REQ-029 SHALL leave entry storage contents uncleared; storage is unobservable while count=0.

Configuration
REQ-030 SHALL compile the same-cycle bypass only when macro FETCH_QUEUE_BYPASS_EN is defined.
REQ-031 SHALL, with FETCH_QUEUE_BYPASS_EN defined, while count=0 and flush=0: drive out_valid=in_valid, out_inst=in_inst, out_pc=in_pc combinationally; if out_ready=1, consume the entry without writing it; otherwise write it normally.
REQ-032 SHALL, without FETCH_QUEUE_BYPASS_EN, have no combinational path from in_* to out_*; REQ-022/023 apply unchanged.

Verification
REQ-033 SHALL cover reset: rst=1 for 2 cycles after random pushes -> count=0, out_valid=0, pc_stall=0, out_pc=0.
REQ-034 SHALL cover fill and drain (DEPTH=4, out_ready=0): push pc 0x0,0x4,0x8,0xC -> count=4 and pc_stall=1. 5th push pc 0x10 ignored. Raise out_ready -> out_pc 0x0,0x4,0x8,0xC in order, then out_valid=0.
REQ-035 SHALL cover wrap-around: push/pop continuously for 10 entries with pc 0x100+4i -> outputs in order with no loss, count stable at 1 (no bypass).
REQ-036 SHALL cover flush: with count=3, flush=1 together with in_valid=1 (pc 0x200) -> next cycle count=0, out_valid=0, and pc 0x200 never appears.
REQ-037 SHALL cover full with simultaneous pop: count=4, in_valid=1 (pc 0x300), out_ready=1 -> count=3, and pc 0x300 is not enqueued.
REQ-038 SHALL cover bypass: with FETCH_QUEUE_BYPASS_EN, empty, in_valid=1 (inst 0x00000013, pc 0x400), out_ready=1 -> same cycle out_valid=1 and out_pc=0x400, count stays 0. Without the macro -> out_valid=0 that cycle, then 1 the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction fetch queue between fetch and decode.
// Latency: a pushed entry reaches out_valid the cycle after the push. With
//   FETCH_QUEUE_BYPASS_EN defined, an entry that arrives while the queue is
//   empty is presented combinationally in the same cycle.
// Backpressure: pc_stall is high while full, and pushes are dropped then.
//   out_ready pops the head entry.
// Ports: clk/rst (sync, active-high), flush, in_valid/in_inst/in_pc (fetch side),
//   pc_stall, out_valid/out_inst/out_pc/out_ready (decode side), count (occupancy).
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (same-cycle empty-queue bypass).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     pc_stall,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            push;
  logic            pop;
  logic            empty;

  assign empty    = (count == '0);
  assign pc_stall = (count == FULL_CNT);

  // Pop only ever drains stored entries; a bypassed entry is never stored.
  assign pop = !empty && out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_take;
  // Entry handed straight to decode while the queue is empty: not written.
  assign bypass_take = empty && !flush && in_valid && out_ready;
  assign push        = in_valid && (count < FULL_CNT) && !flush && !bypass_take;
`else
  assign push        = in_valid && (count < FULL_CNT) && !flush;
`endif

  // Pointers and occupancy; rst beats flush, flush drops same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // Power-of-two depth: natural pointer overflow wraps DEPTH-1 -> 0.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is never cleared; it is masked on the outputs while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  always_comb begin
    out_valid = !empty;
    out_inst  = '0;
    out_pc    = '0;
    if (!empty) begin
      out_inst = mem_inst[rd_ptr];
      out_pc   = mem_pc[rd_ptr];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && !flush) begin
      out_valid = in_valid;
      if (in_valid) begin
        out_inst = in_inst;
        out_pc   = in_pc;
      end
    end
`endif
  end

endmodule
